// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit and the controller that drives MDOP.
package md_pkg;

   localparam int unsigned XLEN            = 32;
   localparam int unsigned MDOP_W          = 3;
   localparam int unsigned CNT_W           = 4;
   localparam int unsigned MULT_CYCLES_DEF = 5;
   localparam int unsigned DIV_CYCLES_DEF  = 10;

   typedef enum logic [MDOP_W-1:0] {
      MD_NONE     = 3'b000,
      MD_MULT     = 3'b001,
      MD_MULTU    = 3'b010,
      MD_DIV      = 3'b011,
      MD_DIVU     = 3'b100,
      MD_MTHI     = 3'b101,
      MD_MTLO     = 3'b110,
      MD_NONE_ALT = 3'b111
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

   typedef struct packed {
      logic [XLEN-1:0] hi;
      logic [XLEN-1:0] lo;
   } md_result_t;

   function automatic logic md_is_signed(md_op_e op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Operand/command bus between the EX-stage controller and the multiply/divide unit.
interface mult_div_unit_if;
   import md_pkg::*;

   logic [XLEN-1:0]   A;
   logic [XLEN-1:0]   B;
   logic [MDOP_W-1:0] MDOP;
   logic              Start;
   logic              Busy;
   logic [XLEN-1:0]   HI;
   logic [XLEN-1:0]   LO;

   modport master (output A, B, MDOP, Start, input Busy, HI, LO);
   modport slave  (input A, B, MDOP, Start, output Busy, HI, LO);
endinterface

// File: rtl/mult_div_unit.sv
// Fixed-latency multiply/divide unit: computes at Start, holds the result pending,
// and commits it to the architectural HI/LO registers when the latency counter expires.
module mult_div_unit
   import md_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic            clk,
   input  logic            reset,
   mult_div_unit_if.slave  md
);

   md_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic [XLEN-1:0]   hi_q, hi_d;
   logic [XLEN-1:0]   lo_q, lo_d;
   md_result_t        pend_q, pend_d;

   md_op_e            op;
   logic              sext;
   logic signed [32:0] op_a, op_b, div_b;
   logic signed [63:0] mul_a, mul_b;
   logic              div_by_zero;
   md_result_t        mul_res, div_res;

   // One 33-bit signed datapath covers both signednesses; 0x8000_0000 / -1 fits without overflow.
   always_comb begin
      op          = md_op_e'(md.MDOP);
      sext        = md_is_signed(op);
      op_a        = {sext & md.A[XLEN-1], md.A};
      op_b        = {sext & md.B[XLEN-1], md.B};
      mul_a       = 64'(op_a);
      mul_b       = 64'(op_b);
      mul_res     = mul_a * mul_b;
      div_by_zero = (md.B == '0);
      div_b       = div_by_zero ? 33'sd1 : op_b;
      div_res.lo  = div_by_zero ? '1   : 32'(op_a / div_b);
      div_res.hi  = div_by_zero ? md.A : 32'(op_a % div_b);
   end

   // Next-state, counter and result capture.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      pend_d  = pend_q;

      unique case (state_q)
         ST_IDLE: begin
            if (md.Start) begin
               case (op)
                  MD_MULT, MD_MULTU: begin
                     pend_d  = mul_res;
                     cnt_d   = CNT_W'(MULT_CYCLES);
                     busy_d  = 1'b1;
                     state_d = ST_RUN;
                  end
                  MD_DIV, MD_DIVU: begin
                     pend_d  = div_res;
                     cnt_d   = CNT_W'(DIV_CYCLES);
                     busy_d  = 1'b1;
                     state_d = ST_RUN;
                  end
                  MD_MTHI: hi_d = md.A;
                  MD_MTLO: lo_d = md.A;
                  default: ;
               endcase
            end
         end
         ST_RUN: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               hi_d    = pend_q.hi;
               lo_d    = pend_q.lo;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         pend_q  <= pend_d;
      end
   end

   assign md.Busy = busy_q;
   assign md.HI   = hi_q;
   assign md.LO   = lo_q;

endmodule
